// File: rtl/pow2_arbiter.sv
// Round-robin front end sharing one single-precision squaring unit between N requesters,
// with a WAIT watchdog and a post-reset drain period for a unit that cannot be reset.
module pow2_arbiter #(
    parameter int N       = 4,
    parameter int TIMEOUT = 15,
    parameter int DRAIN   = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [N-1:0]      i_req_valid,
    input  logic [32*N-1:0]   i_req_x,
    output logic [N-1:0]      o_req_ready,
    output logic [N-1:0]      o_resp_valid,
    output logic [31:0]       o_resp_data,
    output logic              o_resp_err,
    output logic [31:0]       o_u_x,
    output logic              o_u_r_i,
    input  logic [31:0]       i_u_res,
    input  logic              i_u_err,
    input  logic              i_u_r_o
);

    localparam int GW = $clog2(N);
    localparam int WW = ($clog2(TIMEOUT + 1) > 4) ? $clog2(TIMEOUT + 1) : 4;
    localparam int DW = $clog2(DRAIN + 1);

    typedef enum logic [1:0] {S_DRAIN, S_IDLE, S_ISSUE, S_WAIT} state_t;

    state_t          r_state;
    logic [DW-1:0]   r_dcnt;
    logic [WW-1:0]   r_wcnt;
    logic [N-1:0]    r_pending;
    logic [31:0]     r_xb [N];
    logic [GW-1:0]   r_ptr;
    logic [GW-1:0]   r_g;
    logic [N-1:0]    r_resp_valid;
    logic [31:0]     r_resp_data;
    logic            r_resp_err;
    logic [31:0]     r_u_x;
    logic            r_u_r_i;

    logic            w_any;
    logic [GW-1:0]   w_next;
    logic [GW-1:0]   w_idx;

    // Nearest pending requester after the last grant wins, so nobody waits more than N-1 grants.
    always_comb begin
        w_any  = 1'b0;
        w_next = r_ptr;
        w_idx  = '0;
        for (int k = 1; k <= N; k++) begin
            w_idx = GW'((int'(r_ptr) + k) % N);
            if (!w_any && r_pending[w_idx]) begin
                w_any  = 1'b1;
                w_next = w_idx;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= S_DRAIN;
            r_dcnt       <= DW'(DRAIN - 1);
            r_wcnt       <= '0;
            r_pending    <= '0;
            r_ptr        <= GW'(N - 1);
            r_g          <= '0;
            r_resp_valid <= '0;
            r_resp_data  <= '0;
            r_resp_err   <= 1'b0;
            r_u_x        <= '0;
            r_u_r_i      <= 1'b0;
        end else begin
            r_resp_valid <= '0;
            r_u_r_i      <= 1'b0;

            for (int i = 0; i < N; i++) begin
                if (i_req_valid[i] && !r_pending[i]) begin
                    r_pending[i] <= 1'b1;
                    r_xb[i]      <= i_req_x[32*i +: 32];
                end
            end

            case (r_state)
                S_DRAIN: begin
                    if (r_dcnt == '0) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_dcnt <= r_dcnt - 1'b1;
                    end
                end
                // Start pulse and operand are registered here so they appear exactly in ISSUE.
                S_IDLE: begin
                    if (w_any) begin
                        r_g     <= w_next;
                        r_u_x   <= r_xb[w_next];
                        r_u_r_i <= 1'b1;
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_wcnt  <= '0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (i_u_r_o) begin
                        r_resp_data       <= i_u_res;
                        r_resp_err        <= i_u_err;
                        r_resp_valid[r_g] <= 1'b1;
                        r_pending[r_g]    <= 1'b0;
                        r_ptr             <= r_g;
                        r_state           <= S_IDLE;
                    end else if (r_wcnt == WW'(TIMEOUT - 1)) begin
                        r_resp_data       <= '0;
                        r_resp_err        <= 1'b1;
                        r_resp_valid[r_g] <= 1'b1;
                        r_pending[r_g]    <= 1'b0;
                        r_ptr             <= r_g;
                        r_dcnt            <= DW'(DRAIN - 1);
                        r_state           <= S_DRAIN;
                    end else begin
                        r_wcnt <= r_wcnt + 1'b1;
                    end
                end
                default: r_state <= S_DRAIN;
            endcase
        end
    end

    assign o_req_ready  = ~r_pending;
    assign o_resp_valid = r_resp_valid;
    assign o_resp_data  = r_resp_data;
    assign o_resp_err   = r_resp_err;
    assign o_u_x        = r_u_x;
    assign o_u_r_i      = r_u_r_i;

endmodule

// File: tb/tb_pow2_arbiter.sv
// Directed bench for pow2_arbiter: a lookup-table squaring unit answers in WAIT cycle 6
// and can be muted to exercise the watchdog.
module tb_pow2_arbiter;

    localparam int N = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [N-1:0]  reqValid = '0;
    logic [127:0]  reqX = '0;
    logic [N-1:0]  reqReady;
    logic [N-1:0]  respValid;
    logic [31:0]   respData;
    logic          respErr;
    logic [31:0]   uX;
    logic          uRi;
    logic [31:0]   uRes;
    logic          uErr;
    logic          uRo;

    int assertCount = 0;
    int failCount   = 0;

    logic [2:0]    unitCnt = '0;
    logic [31:0]   unitX = '0;
    logic          unitMute = 1'b0;

    pow2_arbiter #(.N(N), .TIMEOUT(15), .DRAIN(8)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_req_valid (reqValid),
        .i_req_x     (reqX),
        .o_req_ready (reqReady),
        .o_resp_valid(respValid),
        .o_resp_data (respData),
        .o_resp_err  (respErr),
        .o_u_x       (uX),
        .o_u_r_i     (uRi),
        .i_u_res     (uRes),
        .i_u_err     (uErr),
        .i_u_r_o     (uRo)
    );

    always #5 clk = ~clk;

    // Hand-computed squares of the operands used below; {err, result}.
    function automatic logic [32:0] squareOf(input logic [31:0] x);
        case (x)
            32'h40400000: squareOf = {1'b0, 32'h41100000};
            32'h40000000: squareOf = {1'b0, 32'h40800000};
            32'h3FC00000: squareOf = {1'b0, 32'h40100000};
            32'h40800000: squareOf = {1'b0, 32'h41800000};
            32'h7F000000: squareOf = {1'b1, 32'h7F800000};
            default:      squareOf = {1'b0, 32'h00000000};
        endcase
    endfunction

    // Unit stub with no reset: samples the start on the edge closing ISSUE, done in WAIT cycle 6.
    always @(posedge clk) begin
        if (uRi) begin
            unitCnt <= 3'd1;
            unitX   <= uX;
        end else if (unitCnt == 3'd6) begin
            unitCnt <= 3'd0;
        end else if (unitCnt != 3'd0) begin
            unitCnt <= unitCnt + 3'd1;
        end
    end

    assign uRo = (unitCnt == 3'd6) && !unitMute;
    assign {uErr, uRes} = squareOf(unitX);

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    // Offers the given operands for exactly one edge; returns one cycle after the accept edge.
    task automatic applyStimulus(input logic [N-1:0] v, input logic [127:0] x);
        reqValid = v;
        reqX     = x;
        stepCycle();
        reqValid = '0;
    endtask

    task automatic waitResp(input int limit, output int steps);
        steps = 0;
        do begin
            stepCycle();
            steps++;
        end while (respValid == '0 && steps < limit);
        if (respValid == '0) checkOutput("respTimeout", 64'(respValid), 64'hF);
    endtask

    task automatic resetDut();
        rst = 1'b1;
        stepCycle();
        stepCycle();
        rst = 1'b0;
        repeat (10) stepCycle();
    endtask

    int steps;
    logic seenResp;
    logic seenIssue;
    logic [3:0] expOrder [4];
    logic [31:0] expData [4];

    initial begin
        expOrder = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        expData  = '{32'h40800000, 32'h41100000, 32'h40100000, 32'h41800000};

        $display("[TB] reset values");
        stepCycle();
        stepCycle();
        checkOutput("rstReady", 64'(reqReady), 64'hF);
        checkOutput("rstValid", 64'(respValid), 64'h0);
        checkOutput("rstData", 64'(respData), 64'h0);
        checkOutput("rstErr", 64'(respErr), 64'h0);
        checkOutput("rstUri", 64'(uRi), 64'h0);
        checkOutput("rstUx", 64'(uX), 64'h0);
        rst = 1'b0;
        repeat (10) stepCycle();

        $display("[TB] single request");
        applyStimulus(4'b0001, {96'h0, 32'h40400000});
        checkOutput("singleReadyLow", 64'(reqReady), 64'hE);
        stepCycle();
        checkOutput("singleIssue", 64'(uRi), 64'h1);
        checkOutput("singleUx", 64'(uX), 64'h40400000);
        waitResp(40, steps);
        checkOutput("singleLatency", 64'(steps + 2), 64'd9);
        checkOutput("singleValid", 64'(respValid), 64'h1);
        checkOutput("singleData", 64'(respData), 64'h41100000);
        checkOutput("singleErr", 64'(respErr), 64'h0);
        checkOutput("singleReadyBack", 64'(reqReady), 64'hF);
        stepCycle();
        checkOutput("singlePulse", 64'(respValid), 64'h0);
        checkOutput("singleHold", 64'(respData), 64'h41100000);

        $display("[TB] four simultaneous requests");
        resetDut();
        applyStimulus(4'b1111, {32'h40800000, 32'h3FC00000, 32'h40400000, 32'h40000000});
        for (int k = 0; k < 4; k++) begin
            waitResp(40, steps);
            checkOutput($sformatf("allGap%0d", k), 64'(steps), (k == 0) ? 64'd8 : 64'd8);
            checkOutput($sformatf("allOrder%0d", k), 64'(respValid), 64'(expOrder[k]));
            checkOutput($sformatf("allData%0d", k), 64'(respData), 64'(expData[k]));
        end

        $display("[TB] fairness 0/2");
        resetDut();
        applyStimulus(4'b0101, {32'h0, 32'h40400000, 32'h0, 32'h40000000});
        for (int k = 0; k < 10; k++) begin
            waitResp(40, steps);
            checkOutput($sformatf("fairGrant%0d", k), 64'(respValid), (k % 2 == 0) ? 64'h1 : 64'h4);
            checkOutput($sformatf("fairData%0d", k), 64'(respData),
                        (k % 2 == 0) ? 64'h40800000 : 64'h41100000);
            applyStimulus(respValid, {32'h0, 32'h40400000, 32'h0, 32'h40000000});
        end

        $display("[TB] overflow");
        resetDut();
        applyStimulus(4'b0010, {32'h0, 32'h0, 32'h7F000000, 32'h0});
        waitResp(40, steps);
        checkOutput("ovfLatency", 64'(steps + 1), 64'd9);
        checkOutput("ovfValid", 64'(respValid), 64'h2);
        checkOutput("ovfErr", 64'(respErr), 64'h1);
        checkOutput("ovfData", 64'(respData), 64'h7F800000);

        $display("[TB] watchdog");
        resetDut();
        unitMute = 1'b1;
        applyStimulus(4'b1100, {32'h40400000, 32'h40000000, 32'h0, 32'h0});
        waitResp(40, steps);
        unitMute = 1'b0;
        checkOutput("wdLatency", 64'(steps + 1), 64'd18);
        checkOutput("wdValid", 64'(respValid), 64'h4);
        checkOutput("wdData", 64'(respData), 64'h0);
        checkOutput("wdErr", 64'(respErr), 64'h1);
        seenIssue = 1'b0;
        for (int k = 0; k < 8; k++) begin
            stepCycle();
            seenIssue |= uRi;
        end
        checkOutput("wdDrainQuiet", 64'(seenIssue), 64'h0);
        stepCycle();
        checkOutput("wdReissue", 64'(uRi), 64'h1);
        checkOutput("wdReissueUx", 64'(uX), 64'h40400000);
        waitResp(40, steps);
        checkOutput("wdNextSteps", 64'(steps), 64'd7);
        checkOutput("wdNextValid", 64'(respValid), 64'h8);
        checkOutput("wdNextData", 64'(respData), 64'h41100000);
        checkOutput("wdNextErr", 64'(respErr), 64'h0);

        $display("[TB] reset mid-WAIT");
        resetDut();
        applyStimulus(4'b0010, {32'h0, 32'h0, 32'h40400000, 32'h0});
        repeat (4) stepCycle();
        rst = 1'b1;
        stepCycle();
        rst = 1'b0;
        seenResp  = 1'b0;
        seenIssue = 1'b0;
        for (int k = 0; k < 20; k++) begin
            seenResp  |= (respValid != '0);
            seenIssue |= uRi;
            stepCycle();
        end
        checkOutput("midRstNoResp", 64'(seenResp), 64'h0);
        checkOutput("midRstNoIssue", 64'(seenIssue), 64'h0);
        checkOutput("midRstReady", 64'(reqReady), 64'hF);
        applyStimulus(4'b0001, {96'h0, 32'h40800000});
        waitResp(40, steps);
        checkOutput("midRstLatency", 64'(steps + 1), 64'd9);
        checkOutput("midRstValid", 64'(respValid), 64'h1);
        checkOutput("midRstData", 64'(respData), 64'h41800000);
        checkOutput("midRstErr", 64'(respErr), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/pow2_arbiter.md
# pow2_arbiter

Round-robin front end that shares one floating-point squaring unit between N requesters. Each requester hands over an IEEE-754 single-precision operand through a valid/ready handshake. The arbiter issues one operand at a time to the unit on its `r_i`/`r_o` handshake and routes the result and error flag back to the owning requester. A watchdog covers a unit that never answers. A drain period after reset guards against a unit that has no reset of its own.

## Interface
- `N`, default 4: number of requesters, 2..8.
- `TIMEOUT`, default 15: WAIT cycles allowed before the watchdog fires; must be > 6.
- `DRAIN`, default 8: idle cycles forced after reset and after a timeout.
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `req_valid`  in  N: requester i offers an operand.
- `req_x`  in  32*N: operand i in bits [32i+31:32i]; sign bit 31, exponent 30:23, mantissa 22:0.
- `req_ready`  out  N: requester i has no operand buffered or in flight.
- `resp_valid`  out  N: one-cycle pulse; result for requester i.
- `resp_data`  out  32: squared value, shared by all requesters.
- `resp_err`  out  1: overflow flag from the unit, or watchdog timeout.
- `u_x`  out  32: operand to the unit.
- `u_r_i`  out  1: start pulse to the unit.
- `u_res`  in  32: unit result.
- `u_err`  in  1: unit error flag.
- `u_r_o`  in  1: unit done pulse.

## Operation
- Storage:
  - One operand buffer `xb[i]` and one `pending[i]` flag per requester.
  - Round-robin pointer `ptr` holds the last granted index.
  - Owner register `g`.
  - WAIT counter `wcnt`, 4+ bits.
  - Drain counter.
- Accept: on an edge with `req_valid[i] && req_ready[i]`, set `xb[i]<=req_x[i]` and `pending[i]<=1`. `req_ready[i] = !pending[i]`; `pending` stays set until the response for i.
- FSM states: DRAIN, IDLE, ISSUE, WAIT.
  - **DRAIN**: count `DRAIN` cycles, then go to IDLE. Requests are accepted here, but nothing is issued.
  - **IDLE**: if any `pending`, set `g` to the first pending index searching `ptr+1, ptr+2, …` modulo N. Go to ISSUE. Otherwise stay in IDLE.
  - **ISSUE**: `u_r_i=1` and `u_x=xb[g]` for exactly this cycle. Clear `wcnt`. Go to WAIT.
  - **WAIT**: `wcnt` increments each cycle.
    - If `u_r_o=1`: register `resp_data<=u_res`, `resp_err<=u_err`, `resp_valid[g]<=1`, `pending[g]<=0`, `ptr<=g`. Go to IDLE.
    - Else, when `wcnt` reaches `TIMEOUT`: register `resp_data<=0`, `resp_err<=1`, `resp_valid[g]<=1`, `pending[g]<=0`, `ptr<=g`. Go to DRAIN.
- Outside the ISSUE cycle, `u_r_i=0` and `u_x` holds its last value.
- `u_r_o` is ignored in every state except WAIT; stray pulses have no effect.
- `resp_valid` is one-hot or zero and lasts exactly one cycle. `resp_data` and `resp_err` hold their values until the next response.
- Only one operation is in flight. Fairness: a continuously pending requester waits at most N−1 other grants.

## Timing
- Reset values:
  - Outputs: `req_ready` all 1, `resp_valid` 0, `resp_data` 0, `resp_err` 0, `u_r_i` 0, `u_x` 0.
  - Internal: `pending` 0, `ptr=N-1` (so the first search starts at 0), state DRAIN with counter loaded.
- Reset mid-operation: the in-flight request and all buffered requests are dropped with no response. The following DRAIN period lets the unit finish on its own; its late `u_r_o` is ignored.
- Unit contract:
  - The unit samples `u_r_i` on the edge closing ISSUE.
  - `u_r_o` is high in WAIT cycle 6.
  - The unit is ready for a new start from the cycle of its `u_r_o`.
- Latency with an idle arbiter, with accept at edge A:
  - IDLE in cycle A+1.
  - ISSUE in A+2.
  - WAIT in A+3..A+8.
  - `resp_valid` high in cycle A+9.
- Throughput: one operation per 8 cycles (IDLE, ISSUE, 6×WAIT). The response cycle is the IDLE cycle of the next grant.
- Re-request: `req_ready[i]` returns to 1 in the same cycle as `resp_valid[i]`, so requester i can be re-accepted on that cycle's closing edge.
- Simultaneous arrivals: several requesters accepted on the same edge are served in pointer order, starting at `ptr+1`.

## Test plan
- **Single request, real squaring unit:** after reset and drain, requester 0 sends `0x40400000` (3.0) → `resp_valid=0001` exactly 9 cycles after accept, `resp_data=0x41100000`, `resp_err=0`.
- **All four requesters valid on one edge:**
  - Operands: 2.0 `0x40000000`, 3.0, 1.5 `0x3FC00000`, 4.0 `0x40800000`.
  - Responses come in order 0,1,2,3, spaced 8 cycles apart.
  - Data: `0x40800000`, `0x41100000`, `0x40100000`, `0x41800000`.
- **Fairness:** requesters 0 and 2 re-request immediately after every response → grants alternate 0,2,0,2 and neither is starved over 10 operations.
- **Overflow:** requester 1 sends `0x7F000000` → `resp_err=1`, response delivered to requester 1 only.
- **Watchdog:** stub unit never pulses `u_r_o`.
  - `resp_valid[g]` fires after `TIMEOUT` WAIT cycles with `resp_data=0`, `resp_err=1`.
  - Then 8 DRAIN cycles with `u_r_i=0`.
  - The next pending request then issues normally.
- **Reset mid-WAIT:** assert `rst` in WAIT cycle 3 → no `resp_valid` follows. The unit's late `u_r_o` is ignored, `req_ready` is all 1, and the first post-reset request returns a correct result.
